// File: rtl/l1_line_bridge_if.sv
// Bundle of the L1 line-side request port and the narrow memory beat port.
// The bridge takes the master view; the L1 requester / memory environment takes the slave view.
interface l1_line_bridge_if #(
    parameter int LINE_SIZE  = 64,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]    l1_addr;
    logic [LINE_SIZE*8-1:0]   l1_wdata;
    logic                     l1_rd;
    logic                     l1_wr;
    logic [LINE_SIZE*8-1:0]   l1_rdata;
    logic                     l1_ready;
    logic                     mem_valid;
    logic                     mem_ready;
    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [BEAT_WIDTH-1:0]    mem_wdata;
    logic                     mem_rvalid;
    logic [BEAT_WIDTH-1:0]    mem_rdata;
    logic                     busy;

    modport master (
        input  l1_addr, l1_wdata, l1_rd, l1_wr, mem_ready, mem_rvalid, mem_rdata,
        output l1_rdata, l1_ready, mem_valid, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output l1_addr, l1_wdata, l1_rd, l1_wr, mem_ready, mem_rvalid, mem_rdata,
        input  l1_rdata, l1_ready, mem_valid, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/l1_line_bridge.sv
// Splits one full-line L1 write-back or fill into BEATS narrow memory beats and
// reassembles read beats into a line; one line transaction in flight at a time.
module l1_line_bridge #(
    parameter int LINE_SIZE  = 64,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    l1_line_bridge_if.master bus
);
    localparam int LINE_W     = LINE_SIZE * 8;
    localparam int BEATS      = LINE_W / BEAT_WIDTH;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int OFF_W      = $clog2(LINE_SIZE);
    localparam int BYTE_OFF_W = $clog2(BEAT_WIDTH / 8);
    localparam int CNT_W      = BEAT_IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_BEATS = CNT_W'(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        WR_BEATS,
        RD,
        RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;
    logic [LINE_W-1:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
    logic [LINE_W-1:0]      fill_q, fill_d;
    logic [LINE_W-1:0]      l1_rdata_q, l1_rdata_d;
    logic                   l1_ready_q, l1_ready_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [BEAT_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

    logic [BEAT_WIDTH-1:0]  wr_beat [BEATS];
    logic [LINE_W-1:0]      fill_next;
    logic                   rd_take;

    assign rd_take = (state_q == RD) && bus.mem_rvalid;

    // Beat gi covers line bits [gi*BEAT_WIDTH +: BEAT_WIDTH]; fill_next is the
    // fill buffer with the current response dropped into slot rsp_cnt.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign wr_beat[gi] = wdata_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
        assign fill_next[gi*BEAT_WIDTH +: BEAT_WIDTH] =
            (rsp_cnt_q[BEAT_IDX_W-1:0] == BEAT_IDX_W'(gi)) ? bus.mem_rdata
                                                           : fill_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        wdata_d     = wdata_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        fill_d      = fill_q;
        l1_rdata_d  = l1_rdata_q;
        l1_ready_d  = 1'b0;
        mem_valid_d = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                issue_cnt_d = '0;
                rsp_cnt_d   = '0;
                if (bus.l1_wr || bus.l1_rd) begin
                    line_base_d = {bus.l1_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d     = bus.l1_wdata;
                    mem_we_d    = bus.l1_wr;
                    state_d     = bus.l1_wr ? WR_BEATS : RD;
                end
            end

            WR_BEATS, RD: begin
                if (mem_valid_q && bus.mem_ready) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                // A stalled beat keeps issue_cnt, so address and data are re-presented unchanged.
                mem_valid_d = (issue_cnt_d < CNT_BEATS);
                if (mem_valid_d) begin
                    mem_addr_d  = line_base_q + (ADDR_WIDTH'(issue_cnt_d) << BYTE_OFF_W);
                    mem_wdata_d = mem_we_q ? wr_beat[issue_cnt_d[BEAT_IDX_W-1:0]] : '0;
                end

                if (state_q == WR_BEATS) begin
                    if (!mem_valid_d) begin
                        state_d    = RESP;
                        l1_ready_d = 1'b1;
                    end
                end else if (rd_take) begin
                    fill_d    = fill_next;
                    rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
                    if (rsp_cnt_d == CNT_BEATS) begin
                        state_d     = RESP;
                        l1_ready_d  = 1'b1;
                        l1_rdata_d  = fill_next;
                        mem_valid_d = 1'b0;
                    end
                end
            end

            RESP: begin
                state_d     = IDLE;
                issue_cnt_d = '0;
                rsp_cnt_d   = '0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_base_q <= '0;
            wdata_q     <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            fill_q      <= '0;
            l1_rdata_q  <= '0;
            l1_ready_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            wdata_q     <= wdata_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            fill_q      <= fill_d;
            l1_rdata_q  <= l1_rdata_d;
            l1_ready_q  <= l1_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.l1_rdata  = l1_rdata_q;
    assign bus.l1_ready  = l1_ready_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_l1_line_bridge.sv
// Scoreboard bench for l1_line_bridge: the requester pushes expected beats and
// completions, a negedge monitor pops and compares, and a memory model answers reads.
module tb_l1_line_bridge;
    localparam int LINE_SIZE  = 64;
    localparam int BEAT_WIDTH = 64;
    localparam int ADDR_WIDTH = 32;
    localparam int LINE_W     = LINE_SIZE * 8;
    localparam int BEATS      = LINE_W / BEAT_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    l1_line_bridge_if #(.LINE_SIZE(LINE_SIZE), .BEAT_WIDTH(BEAT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    l1_line_bridge #(.LINE_SIZE(LINE_SIZE), .BEAT_WIDTH(BEAT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [511:0] rdata;
        int           due;
        bit           is_rd;
        logic [31:0]  base;
    } done_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    beat_t exp_beat_q[$];
    done_t exp_done_q[$];
    rsp_t  rsp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_count = 0;
    int done_count = 0;
    int last_rv_cyc = -100;
    int ready_mode = 0;
    int ready_phase = 0;
    int latency = 3;
    int stray_n = 0;
    logic [511:0] last_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents as seen by the bridge: every beat address returns a fixed pattern.
    function automatic logic [63:0] mem_fn(input logic [31:0] a);
        return {32'd0, a ^ 32'h0000_A5A5};
    endfunction

    function automatic logic [511:0] read_line(input logic [31:0] base);
        logic [511:0] r;
        for (int i = 0; i < BEATS; i++) r[i*64 +: 64] = mem_fn(base + 32'(i * 8));
        return r;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_valid"}, bus.mem_valid, 1'b0);
        check({tag, "_l1_ready"},  bus.l1_ready,  1'b0);
        check({tag, "_busy"},      bus.busy,      1'b0);
        check({tag, "_l1_rdata"},  bus.l1_rdata,  '0);
        check({tag, "_mem_we"},    bus.mem_we,    1'b0);
        check({tag, "_mem_addr"},  bus.mem_addr,  '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    endtask

    // Requester: called just after a posedge; holds rd/wr until l1_ready is seen.
    task automatic l1_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [511:0] line, input bit chk_lat, input int abort_hs);
        logic [31:0] base;
        int hs0;
        bit got;
        bit aborted;
        base = {addr[31:6], 6'd0};
        for (int i = 0; i < BEATS; i++)
            exp_beat_q.push_back(beat_t'{addr: base + 32'(i * 8), we: wr,
                                         data: wr ? line[i*64 +: 64] : 64'd0});
        if (!wr) last_line = read_line(base);
        exp_done_q.push_back(done_t'{rdata: last_line, due: chk_lat ? cyc + BEATS + 2 : -1,
                                     is_rd: !wr, base: base});
        bus.l1_addr  = addr;
        bus.l1_wdata = line;
        bus.l1_rd    = rd;
        bus.l1_wr    = wr;
        hs0 = hs_count;
        got = 1'b0;
        aborted = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n == 1 && abort_hs == 0) check("busy_on_capture", bus.busy, 1'b1);
            if (abort_hs > 0 && (hs_count - hs0) >= abort_hs) begin
                aborted = 1'b1;
                break;
            end
            if (bus.l1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got && !aborted) begin
            checks++;
            errors++;
            $display("FAIL l1_ready_timeout: got no l1_ready expected one within 300 cycles (base %h)", base);
        end
        @(posedge clk);
        #1;
        bus.l1_rd = 1'b0;
        bus.l1_wr = 1'b0;
        if (aborted) rst = 1'b1;
    endtask

    // Memory driver: ready pattern plus in-order read responses, driven just after each posedge.
    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.mem_ready = 1'b1;
                1: begin
                    bus.mem_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                    ready_phase++;
                end
                default: bus.mem_ready = 1'($urandom_range(0, 1));
            endcase
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end else if (stray_n > 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = {$urandom, $urandom};
                stray_n--;
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit stall_prev;
        logic [31:0] p_addr;
        logic [63:0] p_data;
        beat_t e;
        done_t d;
        stall_prev = 1'b0;
        p_addr = '0;
        p_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_beat_q.delete();
                exp_done_q.delete();
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                check("stall_valid", bus.mem_valid, 1'b1);
                check("stall_addr",  bus.mem_addr,  p_addr);
                check("stall_wdata", bus.mem_wdata, p_data);
            end
            stall_prev = bus.mem_valid && !bus.mem_ready;
            p_addr = bus.mem_addr;
            p_data = bus.mem_wdata;

            if (bus.mem_valid && bus.mem_ready) begin
                hs_count++;
                if (!bus.mem_we) rsp_q.push_back(rsp_t'{due: cyc + latency, data: mem_fn(bus.mem_addr)});
                if (exp_beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got beat at %h expected no beat", bus.mem_addr);
                end else begin
                    e = exp_beat_q.pop_front();
                    check("beat_addr", bus.mem_addr, e.addr);
                    check("beat_we",   bus.mem_we,   e.we);
                    if (e.we) check("beat_wdata", bus.mem_wdata, e.data);
                end
            end

            if (bus.l1_ready) begin
                done_count++;
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL l1_ready_unexpected: got l1_ready=1 expected 0 at cycle %0d", cyc);
                end else begin
                    d = exp_done_q.pop_front();
                    check("l1_rdata", bus.l1_rdata, d.rdata);
                    check("busy_in_resp", bus.busy, 1'b1);
                    if (d.due >= 0) check("wr_latency", 512'(cyc), 512'(d.due));
                    if (d.is_rd) check("rd_latency", 512'(cyc), 512'(last_rv_cyc + 1));
                    $display("txn %0d %s base=%h done at cycle %0d", done_count,
                             d.is_rd ? "read " : "write", d.base, cyc);
                end
            end
            if (bus.mem_rvalid) last_rv_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] line;
        int hs0;
        int d0;
        int op;
        bus.l1_addr  = '0;
        bus.l1_wdata = '0;
        bus.l1_rd    = 1'b0;
        bus.l1_wr    = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write-back at 0x1234, beat i = 0x1111..11 * (i+1), full-speed memory.
        ready_mode = 0;
        for (int i = 0; i < BEATS; i++) line[i*64 +: 64] = 64'h1111_1111_1111_1111 * (i + 1);
        l1_req(1'b0, 1'b1, 32'h0000_1234, line, 1'b1, 0);
        @(negedge clk);
        check("busy_after_wr", bus.busy, 1'b0);
        @(posedge clk);
        #1;

        // Line fill, read latency 3.
        latency = 3;
        l1_req(1'b1, 1'b0, 32'h0004_0040, '0, 1'b0, 0);

        // Backpressure 1,0,0,1 during a write.
        ready_mode  = 1;
        ready_phase = 0;
        hs0 = hs_count;
        l1_req(1'b0, 1'b1, 32'h00AB_CDC0, rand_line(), 1'b0, 0);
        check("bp_handshakes", 512'(hs_count - hs0), 512'(BEATS));
        ready_mode = 0;

        // Dirty-line eviction followed immediately by the fill.
        d0 = done_count;
        l1_req(1'b0, 1'b1, 32'h0010_2080, rand_line(), 1'b1, 0);
        l1_req(1'b1, 1'b0, 32'h0010_2080, '0, 1'b0, 0);
        check("b2b_pulses", 512'(done_count - d0), 512'd2);

        // Simultaneous rd and wr: write wins, l1_rdata untouched.
        l1_req(1'b1, 1'b1, 32'h0000_3FC0, rand_line(), 1'b1, 0);

        // Reset after 3 read beats, then stray responses, then a clean read.
        latency = 3;
        l1_req(1'b1, 1'b0, 32'h0000_8000, '0, 1'b0, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_line = '0;
        d0 = done_count;
        stray_n = 4;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("stray_busy", bus.busy, 1'b0);
        check("stray_l1_rdata", bus.l1_rdata, '0);
        check("stray_no_ready", 512'(done_count - d0), 512'd0);
        @(posedge clk);
        #1;
        l1_req(1'b1, 1'b0, 32'h0000_8000, '0, 1'b0, 0);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            op = int'($urandom_range(0, 3));
            ready_mode = ($urandom_range(0, 1) == 1) ? 0 : 2;
            latency = int'($urandom_range(1, 5));
            line = rand_line();
            l1_req(op != 0, (op == 0) || (op == 2), $urandom, line,
                   ((op == 0) || (op == 2)) && (ready_mode == 0), 0);
        end

        repeat (5) @(posedge clk);
        check("exp_beats_left", 512'(exp_beat_q.size()), 512'd0);
        check("exp_done_left", 512'(exp_done_q.size()), 512'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
